// File: rtl/butterfly_mac_sequencer.sv
// Front end for the serial complex MAC: takes one butterfly request, streams its
// operands over count 0..3, then holds the MAC results behind a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a request, operand buses parked at 0
// RUN   | streaming operands, count 0..3, flag high
// CAP   | count 4, waiting to move MAC results into Y*

module butterfly_mac_sequencer #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 10
) (
    input  logic             clk_MAC,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] A_R,
    input  logic [WIDTH-1:0] A_I,
    input  logic [WIDTH-1:0] B_R,
    input  logic [WIDTH-1:0] B_I,
    input  logic [WIDTH-1:0] W_R,
    input  logic [WIDTH-1:0] W_I,
    output logic [WIDTH-1:0] in_A,
    output logic [WIDTH-1:0] in_B,
    output logic [WIDTH-1:0] in_W,
    output logic [2:0]       count,
    output logic             flag,
    input  logic [WIDTH-1:0] OUT1_R,
    input  logic [WIDTH-1:0] OUT1_I,
    input  logic [WIDTH-1:0] OUT2_R,
    input  logic [WIDTH-1:0] OUT2_I,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] Y1_R,
    output logic [WIDTH-1:0] Y1_I,
    output logic [WIDTH-1:0] Y2_R,
    output logic [WIDTH-1:0] Y2_I,
    output logic             busy
);

    if (FRAC >= WIDTH) begin : g_frac_check
        $error("FRAC must be smaller than WIDTH");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, CAP = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [2:0]       count_q, count_d;
    logic             flag_q, flag_d;
    logic             req_ready_q, req_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] in_a_q, in_a_d, in_b_q, in_b_d, in_w_q, in_w_d;
    logic [WIDTH-1:0] a_r_q, a_r_d, a_i_q, a_i_d, b_r_q, b_r_d;
    logic [WIDTH-1:0] b_i_q, b_i_d, w_r_q, w_r_d, w_i_q, w_i_d;
    logic [WIDTH-1:0] y1_r_q, y1_r_d, y1_i_q, y1_i_d, y2_r_q, y2_r_d, y2_i_q, y2_i_d;
    logic             req_hs, capture;
    logic [1:0]       step;

    assign req_hs  = req_valid & req_ready_q;
    assign capture = (state_q == CAP) & (~res_valid_q | res_ready);
    assign step    = count_q[1:0] + 2'd1;

    always_ff @(posedge clk_MAC) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_hs) state_d = RUN;
            RUN:     if (count_q == 3'd3) state_d = CAP;
            CAP:     if (capture) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d     = count_q;
        flag_d      = (state_d == RUN);
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        res_valid_d = res_valid_q & ~res_ready;
        in_a_d = in_a_q;  in_b_d = in_b_q;  in_w_d = in_w_q;
        a_r_d  = a_r_q;   a_i_d  = a_i_q;   b_r_d  = b_r_q;
        b_i_d  = b_i_q;   w_r_d  = w_r_q;   w_i_d  = w_i_q;
        y1_r_d = y1_r_q;  y1_i_d = y1_i_q;  y2_r_d = y2_r_q;  y2_i_d = y2_i_q;
        case (state_q)
            IDLE: begin
                count_d = 3'd0;
                in_a_d  = '0;
                in_b_d  = '0;
                in_w_d  = '0;
                if (req_hs) begin
                    a_r_d = A_R;  a_i_d = A_I;  b_r_d = B_R;
                    b_i_d = B_I;  w_r_d = W_R;  w_i_d = W_I;
                    in_a_d = A_R;
                    in_b_d = B_R;
                    in_w_d = W_R;
                end
            end
            RUN: begin
                if (count_q == 3'd3) begin
                    count_d = 3'd4;
                end else begin
                    count_d = count_q + 3'd1;
                    // step 1: A_R,B_I,W_I  step 2: A_I,B_R,W_I  step 3: A_I,B_I,W_R
                    in_a_d  = step[1] ? a_i_q : a_r_q;
                    in_b_d  = step[0] ? b_i_q : b_r_q;
                    in_w_d  = (step[1] ^ step[0]) ? w_i_q : w_r_q;
                end
            end
            CAP: begin
                count_d = 3'd4;
                if (capture) begin
                    count_d     = 3'd0;
                    in_a_d      = '0;
                    in_b_d      = '0;
                    in_w_d      = '0;
                    res_valid_d = 1'b1;
                    y1_r_d = OUT1_R;  y1_i_d = OUT1_I;
                    y2_r_d = OUT2_R;  y2_i_d = OUT2_I;
                end
            end
            default: count_d = 3'd0;
        endcase
    end

    always_ff @(posedge clk_MAC) begin
        if (rst) begin
            count_q     <= 3'd0;
            flag_q      <= 1'b0;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_a_q <= '0;  in_b_q <= '0;  in_w_q <= '0;
            a_r_q  <= '0;  a_i_q  <= '0;  b_r_q  <= '0;
            b_i_q  <= '0;  w_r_q  <= '0;  w_i_q  <= '0;
            y1_r_q <= '0;  y1_i_q <= '0;  y2_r_q <= '0;  y2_i_q <= '0;
        end else begin
            count_q     <= count_d;
            flag_q      <= flag_d;
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            in_a_q <= in_a_d;  in_b_q <= in_b_d;  in_w_q <= in_w_d;
            a_r_q  <= a_r_d;   a_i_q  <= a_i_d;   b_r_q  <= b_r_d;
            b_i_q  <= b_i_d;   w_r_q  <= w_r_d;   w_i_q  <= w_i_d;
            y1_r_q <= y1_r_d;  y1_i_q <= y1_i_d;  y2_r_q <= y2_r_d;  y2_i_q <= y2_i_d;
        end
    end

    assign count     = count_q;
    assign flag      = flag_q;
    assign req_ready = req_ready_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign in_A      = in_a_q;
    assign in_B      = in_b_q;
    assign in_W      = in_w_q;
    assign Y1_R      = y1_r_q;
    assign Y1_I      = y1_i_q;
    assign Y2_R      = y2_r_q;
    assign Y2_I      = y2_i_q;

endmodule

// File: tb/tb_butterfly_mac_sequencer.sv
// Bench for butterfly_mac_sequencer: a behavioural serial MAC feeds results back,
// and a direct complex-arithmetic model plus a request queue predicts every Y.

module tb_butterfly_mac_sequencer;

    logic        clk_MAC = 1'b0;
    logic        rst, req_valid, req_ready, flag, res_valid, res_ready, busy;
    logic [15:0] A_R, A_I, B_R, B_I, W_R, W_I, in_A, in_B, in_W;
    logic [15:0] OUT1_R = '0, OUT1_I = '0, OUT2_R = '0, OUT2_I = '0;
    logic [15:0] Y1_R, Y1_I, Y2_R, Y2_I;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk_MAC = ~clk_MAC;

    butterfly_mac_sequencer #(.WIDTH(16), .FRAC(10)) dut (
        .clk_MAC(clk_MAC), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .A_R(A_R), .A_I(A_I), .B_R(B_R), .B_I(B_I), .W_R(W_R), .W_I(W_I),
        .in_A(in_A), .in_B(in_B), .in_W(in_W), .count(count), .flag(flag),
        .OUT1_R(OUT1_R), .OUT1_I(OUT1_I), .OUT2_R(OUT2_R), .OUT2_I(OUT2_I),
        .res_valid(res_valid), .res_ready(res_ready),
        .Y1_R(Y1_R), .Y1_I(Y1_I), .Y2_R(Y2_R), .Y2_I(Y2_I), .busy(busy)
    );

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    // Serial MAC: real part loads after count 1, imaginary after count 3, only while flag=1
    longint acc_r = 0, acc_i = 0;
    always @(posedge clk_MAC) begin
        if (flag) begin
            case (count)
                3'd0: acc_r <= sx(in_B) * sx(in_W);
                3'd1: begin
                    OUT1_R <= 16'(sx(in_A) + ((acc_r - sx(in_B) * sx(in_W)) >>> 10));
                    OUT2_R <= 16'(sx(in_A) - ((acc_r - sx(in_B) * sx(in_W)) >>> 10));
                end
                3'd2: acc_i <= sx(in_B) * sx(in_W);
                3'd3: begin
                    OUT1_I <= 16'(sx(in_A) + ((acc_i + sx(in_B) * sx(in_W)) >>> 10));
                    OUT2_I <= 16'(sx(in_A) - ((acc_i + sx(in_B) * sx(in_W)) >>> 10));
                end
                default: ;
            endcase
        end
    end

    // ops packing: {ar, ai, br, bi, wr, wi}; result packing: {y1r, y1i, y2r, y2i}
    function automatic logic [63:0] bfly(input logic [95:0] o);
        longint pr, pi;
        pr = sx(o[63:48]) * sx(o[31:16]) - sx(o[47:32]) * sx(o[15:0]);
        pi = sx(o[63:48]) * sx(o[15:0]) + sx(o[47:32]) * sx(o[31:16]);
        return {16'(sx(o[95:80]) + (pr >>> 10)), 16'(sx(o[79:64]) + (pi >>> 10)),
                16'(sx(o[95:80]) - (pr >>> 10)), 16'(sx(o[79:64]) - (pi >>> 10))};
    endfunction

    function automatic logic [95:0] rand_ops();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [95:0] o);
        {A_R, A_I, B_R, B_I, W_R, W_I} = o;
    endtask

    function automatic logic [63:0] y_all();
        return {Y1_R, Y1_I, Y2_R, Y2_I};
    endfunction

    // Entered at a negedge in IDLE; returns at the negedge of cycle t+6
    task automatic run_seq(input logic [95:0] o, input bit expect_capture);
        logic [15:0] ar, ai, br, bi, wr, wi, ea, eb, ew;
        {ar, ai, br, bi, wr, wi} = o;
        check("entry_req_ready", req_ready, 1);
        set_ops(o);
        req_valid = 1'b1;
        @(negedge clk_MAC);
        req_valid = 1'b0;
        set_ops(rand_ops());
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       begin ea = ar; eb = br; ew = wr; end
                1:       begin ea = ar; eb = bi; ew = wi; end
                2:       begin ea = ai; eb = br; ew = wi; end
                default: begin ea = ai; eb = bi; ew = wr; end
            endcase
            check("run_count", count, k);
            check("run_flag", flag, 1);
            check("run_in_A", in_A, ea);
            check("run_in_B", in_B, eb);
            check("run_in_W", in_W, ew);
            check("run_req_ready", req_ready, 0);
            check("run_busy", busy, 1);
            @(negedge clk_MAC);
        end
        check("cap_count", count, 4);
        check("cap_flag", flag, 0);
        check("cap_busy", busy, 1);
        check("cap_in_hold", {in_A, in_B, in_W}, {ai, bi, wr});
        @(negedge clk_MAC);
        if (expect_capture) begin
            check("res_valid", res_valid, 1);
            check("res_y", y_all(), bfly(o));
            check("post_count", count, 0);
            check("post_req_ready", req_ready, 1);
            check("post_busy", busy, 0);
            check("post_buses", {in_A, in_B, in_W}, 48'h0);
        end
    endtask

    logic [95:0] sb_q[$];
    bit          hs_at[0:511];
    int          cyc = 0;
    int          last_hs = -1;

    task automatic sb_cycle(input bit rv, input bit rr, input bit strict);
        logic [95:0] o;
        o = rand_ops();
        set_ops(o);
        req_valid = rv;
        res_ready = rr;
        if (strict && cyc >= 6) check("b2b_res_valid", res_valid, hs_at[cyc-6]);
        if (req_valid && req_ready) begin
            sb_q.push_back(o);
            if (strict && last_hs >= 0) check("b2b_hs_spacing", cyc - last_hs, 6);
            last_hs   = cyc;
            hs_at[cyc] = 1'b1;
        end
        if (res_valid && res_ready) begin
            check("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) check("sb_y", y_all(), bfly(sb_q.pop_front()));
        end
        @(negedge clk_MAC);
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] o1, o2;
        rst = 1'b1; req_valid = 1'b0; res_ready = 1'b1;
        set_ops('0);
        repeat (3) @(negedge clk_MAC);
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_flag", flag, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_y", y_all(), 64'h0);
        check("rst_buses", {in_A, in_B, in_W}, 48'h0);

        run_seq({16'h0400, 16'h0000, 16'h0200, 16'h0200, 16'h0400, 16'h0000}, 1'b1);
        check("t2_y_const", y_all(), 64'h0600_0200_0200_FE00);
        @(negedge clk_MAC);
        check("t2_consumed", res_valid, 0);

        run_seq({16'h0000, 16'h0000, 16'h0400, 16'h0000, 16'h0000, 16'hFC00}, 1'b1);
        check("t3_y_const", y_all(), 64'h0000_FC00_0000_0400);

        for (int i = 0; i < 5; i++) run_seq(rand_ops(), 1'b1);
        @(negedge clk_MAC);
        check("t4_pre_empty", res_valid, 0);

        res_ready = 1'b0;
        o1 = rand_ops();
        o2 = rand_ops();
        run_seq(o1, 1'b1);
        run_seq(o2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_count", count, 4);
            check("stall_flag", flag, 0);
            check("stall_req_ready", req_ready, 0);
            check("stall_res_valid", res_valid, 1);
            check("stall_y_first", y_all(), bfly(o1));
            @(negedge clk_MAC);
        end
        res_ready = 1'b1;
        @(negedge clk_MAC);
        res_ready = 1'b0;
        check("unstall_res_valid", res_valid, 1);
        check("unstall_y_second", y_all(), bfly(o2));
        check("unstall_count", count, 0);
        check("unstall_req_ready", req_ready, 1);
        @(negedge clk_MAC);
        check("held_res_valid", res_valid, 1);
        check("held_y", y_all(), bfly(o2));
        res_ready = 1'b1;
        @(negedge clk_MAC);
        check("t4_consumed", res_valid, 0);

        set_ops(rand_ops());
        req_valid = 1'b1;
        @(negedge clk_MAC);
        req_valid = 1'b0;
        repeat (2) @(negedge clk_MAC);
        check("t5_at_count2", count, 2);
        rst = 1'b1;
        @(negedge clk_MAC);
        rst = 1'b0;
        check("t5_count", count, 0);
        check("t5_flag", flag, 0);
        check("t5_req_ready", req_ready, 1);
        check("t5_res_valid", res_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_y", y_all(), 64'h0);
        for (int i = 0; i < 8; i++) begin
            check("t5_no_capture", {res_valid, count}, 4'h0);
            @(negedge clk_MAC);
        end

        for (int i = 0; i < 40; i++) sb_cycle(1'b1, 1'b1, 1'b1);
        check("b2b_hs_count", last_hs >= 36, 1);
        for (int i = 0; i < 200; i++) sb_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 30 && (sb_q.size() > 0 || res_valid); i++) sb_cycle(1'b0, 1'b1, 1'b0);
        check("drain_queue_empty", sb_q.size(), 0);
        check("drain_res_valid", res_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/butterfly_mac_sequencer.md
Name: butterfly_mac_sequencer

Overview:
- Front-end driver for the serial complex MAC butterfly datapath.
- Accepts one complex butterfly request (A, B, twiddle W, each Q5.10 real/imag) over a valid/ready handshake.
- Time-serialises the operands onto the MAC's single real-valued operand buses, driving `count` and `flag`.
- Captures the MAC's OUT1/OUT2 results into a held result register with its own valid/ready handshake. This is the producer end of the MAC operand interface.

Parameters:
- WIDTH, 16, sample/twiddle word width (two's complement).
- FRAC, 10, fractional bits (Q5.10). Informational only; no arithmetic is done in this block.

Ports:
- clk_MAC  in  1  clock, shared with the MAC.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  butterfly request valid.
- req_ready  out  1  sequencer can accept a request.
- A_R, A_I  in  WIDTH each  butterfly upper input.
- B_R, B_I  in  WIDTH each  butterfly lower input.
- W_R, W_I  in  WIDTH each  twiddle.
- in_A  out  WIDTH  serial A operand to the MAC.
- in_B  out  WIDTH  serial B operand to the MAC.
- in_W  out  WIDTH  serial W operand to the MAC.
- count  out  3  MAC phase counter.
- flag  out  1  MAC load qualifier.
- OUT1_R, OUT1_I, OUT2_R, OUT2_I  in  WIDTH each  MAC results.
- res_valid  out  1  result register holds an unconsumed result.
- res_ready  in  1  downstream accepts the result.
- Y1_R, Y1_I, Y2_R, Y2_I  out  WIDTH each  registered results (Y1 = A+BW, Y2 = A-BW).
- busy  out  1  high in RUN or CAP.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; count 0; flag 0; in_A/in_B/in_W 0; req_ready 1; res_valid 0; Y* 0; busy 0.
- States:
  - IDLE: req_ready=1, flag=0, count=0, operand buses 0.
    - A handshake (req_valid & req_ready) latches A/B/W into internal registers.
    - Next state RUN with count=0.
  - RUN: flag=1; count advances 0,1,2,3, one step per cycle. Operand schedule per count:
    - count 0: in_B=B_R, in_W=W_R, in_A=A_R.
    - count 1: in_B=B_I, in_W=W_I, in_A=A_R (MAC subtracts; real part loads).
    - count 2: in_B=B_R, in_W=W_I, in_A=A_I.
    - count 3: in_B=B_I, in_W=W_R, in_A=A_I (imag part loads).
    - After count 3, go to CAP with count=4.
  - CAP: count=4, flag=0, operand buses hold their last values.
    - If !res_valid | res_ready: latch OUT1_R/I and OUT2_R/I into Y*, set res_valid=1, go to IDLE (count=0).
    - Otherwise stall in CAP. count stays 4, flag stays 0, and the MAC outputs stay stable because they load only when flag=1.
- req_ready is 0 in RUN and CAP. Requests presented then are ignored, not queued.
- Latency:
  - Handshake in cycle t; count 0..3 in cycles t+1..t+4; CAP at t+5; res_valid=1 from t+6.
  - Unstalled throughput is 1 butterfly per 6 cycles.
- Result handshake:
  - res_valid & res_ready clears res_valid next cycle.
  - If a CAP capture coincides with consumption, the new result loads and res_valid stays 1.
  - Y* change only on capture.
- Operand registers change only on a request handshake. Input changes during RUN do not affect the sequence.
- Reset asserted mid-operation aborts the butterfly. Next cycle matches the reset state, no res_valid pulse, partial result discarded.
- `count` never takes values 5..7. `flag` is never 1 outside RUN.

Test Plan:
1. Sequence check: A=(0x0400,0), B=(0x0200,0x0200), W=(0x0400,0).
   - Required: count 0,1,2,3,4 and flag 1,1,1,1,0 in t+1..t+5.
   - Required: in_B = 0x0200 at every count 0..3; in_W = 0x0400,0,0,0x0400 at counts 0..3; in_A = 0x0400,0x0400,0,0 at counts 0..3.
2. Full datapath with the MAC, same stimulus.
   - Required at t+6: Y1=(0x0600,0x0200), Y2=(0x0200,0xFE00), res_valid=1.
3. W=-j: A=(0,0), B=(0x0400,0), W=(0,0xFC00).
   - Required: Y1=(0,0xFC00), Y2=(0,0x0400).
4. Backpressure: res_ready=0 with a result held, then complete a second butterfly.
   - Required: sequencer holds CAP with count=4 and flag=0.
   - Required: first result unchanged on Y*, req_ready=0.
   - Raising res_ready for 1 cycle loads the second result with res_valid staying 1.
5. Reset at count=2.
   - Required: next cycle count=0, flag=0, req_ready=1, res_valid=0, Y*=0.
   - Required: no capture afterwards.
6. Back-to-back requests with req_valid held high and res_ready=1.
   - Required: handshakes exactly 6 cycles apart.
   - Required: each result valid 1 cycle after its CAP.
   - Required: requests ignored while busy=1.
